// File: rtl/pi_loop_core.sv
// PI regulator: out = sat((Kp*e)>>>SHIFT + (Ki*sum_e)>>>SHIFT), one calculation per rising edge of iCal_en.
// Optional macro PI_ANTI_WINDUP_EN enables conditional-integration anti-windup.
module pi_loop_core #(
    parameter int DATA_W    = 20,
    parameter int GAIN_W    = 10,
    parameter int OUT_W     = 12,
    parameter int INT_W     = 24,
    parameter int INT_LIMIT = 1048576,
    parameter int SHIFT     = 8
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic signed [DATA_W-1:0] iTarget_data,
    input  logic signed [DATA_W-1:0] iCurrent_data,
    input  logic        [GAIN_W-1:0] iKp,
    input  logic        [GAIN_W-1:0] iKi,
    input  logic                     iCal_en,
    input  logic                     iClr_int,
    output logic signed [OUT_W-1:0]  oCal_data,
    output logic                     oCal_done,
    output logic                     oSat,
    output logic                     oBusy
);

    localparam int ERR_W = DATA_W + 1;
    localparam int ACC_W = INT_W + 1;
    localparam int P_W   = GAIN_W + 1 + ERR_W;
    localparam int I_W   = GAIN_W + 1 + INT_W;
    localparam int SUM_W = ((P_W > I_W) ? P_W : I_W) + 1;

    localparam logic signed [ACC_W-1:0] LIM_P  = ACC_W'(INT_LIMIT);
    localparam logic signed [ACC_W-1:0] LIM_N  = -LIM_P;
    localparam logic signed [OUT_W-1:0] OUT_HI = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_LO = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERR,
        S_INT,
        S_MUL,
        S_OUT
    } state_t;

    state_t                    state_reg, state_next;
    logic                      en_d_reg;
    logic signed [DATA_W-1:0]  tgt_reg, tgt_next;
    logic signed [DATA_W-1:0]  cur_reg, cur_next;
    logic        [GAIN_W-1:0]  kp_reg, kp_next;
    logic        [GAIN_W-1:0]  ki_reg, ki_next;
    logic signed [ERR_W-1:0]   err_reg, err_next;
    logic signed [INT_W-1:0]   int_acc_reg, int_acc_next;
    logic signed [P_W-1:0]     p_prod_reg, p_prod_next;
    logic signed [I_W-1:0]     i_prod_reg, i_prod_next;
    logic signed [OUT_W-1:0]   cal_data_reg, cal_data_next;
    logic                      done_reg, done_next;
    logic                      sat_reg, sat_next;
    logic                      busy_reg, busy_next;

    logic                      start;
    logic                      hold_int;
    logic signed [GAIN_W:0]    kp_ext;
    logic signed [GAIN_W:0]    ki_ext;
    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [INT_W-1:0]   acc_clamped;
    logic signed [P_W-1:0]     p_shift;
    logic signed [I_W-1:0]     i_shift;
    logic signed [SUM_W-1:0]   out_sum;
    logic signed [OUT_W-1:0]   out_sat;
    logic                      out_clip;

    assign start  = iCal_en & ~en_d_reg;
    assign kp_ext = $signed({1'b0, kp_reg});
    assign ki_ext = $signed({1'b0, ki_reg});

`ifdef PI_ANTI_WINDUP_EN
    // Freeze integration while the last output was clipped and the error pushes further the same way
    assign hold_int = sat_reg & (err_reg[ERR_W-1] == cal_data_reg[OUT_W-1]);
`else
    assign hold_int = 1'b0;
`endif

    // Integrator update evaluated one bit wider so the clamp sees the true sum
    always_comb begin
        acc_sum     = ACC_W'(int_acc_reg) + ACC_W'(err_reg);
        acc_clamped = INT_W'(acc_sum);
        if (acc_sum > LIM_P) begin
            acc_clamped = INT_W'(LIM_P);
        end else if (acc_sum < LIM_N) begin
            acc_clamped = INT_W'(LIM_N);
        end
    end

    always_comb begin
        p_shift  = p_prod_reg >>> SHIFT;
        i_shift  = i_prod_reg >>> SHIFT;
        out_sum  = SUM_W'(p_shift) + SUM_W'(i_shift);
        out_sat  = OUT_W'(out_sum);
        out_clip = 1'b0;
        if (out_sum > SUM_W'(OUT_HI)) begin
            out_sat  = OUT_HI;
            out_clip = 1'b1;
        end else if (out_sum < SUM_W'(OUT_LO)) begin
            out_sat  = OUT_LO;
            out_clip = 1'b1;
        end
    end

    always_comb begin
        state_next    = state_reg;
        tgt_next      = tgt_reg;
        cur_next      = cur_reg;
        kp_next       = kp_reg;
        ki_next       = ki_reg;
        err_next      = err_reg;
        int_acc_next  = int_acc_reg;
        p_prod_next   = p_prod_reg;
        i_prod_next   = i_prod_reg;
        cal_data_next = cal_data_reg;
        done_next     = 1'b0;
        sat_next      = sat_reg;
        busy_next     = busy_reg;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    tgt_next   = iTarget_data;
                    cur_next   = iCurrent_data;
                    kp_next    = iKp;
                    ki_next    = iKi;
                    busy_next  = 1'b1;
                    state_next = S_ERR;
                end
            end
            S_ERR: begin
                err_next   = ERR_W'(tgt_reg) - ERR_W'(cur_reg);
                state_next = S_INT;
            end
            S_INT: begin
                if (!hold_int) begin
                    int_acc_next = acc_clamped;
                end
                state_next = S_MUL;
            end
            S_MUL: begin
                p_prod_next = P_W'(kp_ext) * P_W'(err_reg);
                i_prod_next = I_W'(ki_ext) * I_W'(int_acc_reg);
                state_next  = S_OUT;
            end
            S_OUT: begin
                cal_data_next = out_sat;
                sat_next      = out_clip;
                done_next     = 1'b1;
                busy_next     = 1'b0;
                state_next    = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Clear wins over any integrator update, including the S_INT one
        if (iClr_int) begin
            int_acc_next = '0;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_reg    <= S_IDLE;
            en_d_reg     <= 1'b0;
            int_acc_reg  <= '0;
            cal_data_reg <= '0;
            done_reg     <= 1'b0;
            sat_reg      <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            en_d_reg     <= iCal_en;
            int_acc_reg  <= int_acc_next;
            cal_data_reg <= cal_data_next;
            done_reg     <= done_next;
            sat_reg      <= sat_next;
            busy_reg     <= busy_next;
        end
    end

    // Datapath registers carry no reset; they are always written before being consumed
    always_ff @(posedge iClk) begin
        tgt_reg    <= tgt_next;
        cur_reg    <= cur_next;
        kp_reg     <= kp_next;
        ki_reg     <= ki_next;
        err_reg    <= err_next;
        p_prod_reg <= p_prod_next;
        i_prod_reg <= i_prod_next;
    end

    assign oCal_data = cal_data_reg;
    assign oCal_done = done_reg;
    assign oSat      = sat_reg;
    assign oBusy     = busy_reg;

endmodule

// File: tb/tb_pi_loop_core.sv
// Scoreboard bench for pi_loop_core; honours PI_ANTI_WINDUP_EN in its reference model.
module tb_pi_loop_core;

    localparam int DATA_W    = 20;
    localparam int GAIN_W    = 10;
    localparam int OUT_W     = 12;
    localparam int INT_W     = 24;
    localparam int INT_LIMIT = 1048576;
    localparam int SHIFT     = 8;

    logic                     iClk = 1'b0;
    logic                     iRst;
    logic signed [DATA_W-1:0] iTarget_data;
    logic signed [DATA_W-1:0] iCurrent_data;
    logic        [GAIN_W-1:0] iKp;
    logic        [GAIN_W-1:0] iKi;
    logic                     iCal_en;
    logic                     iClr_int;
    logic signed [OUT_W-1:0]  oCal_data;
    logic                     oCal_done;
    logic                     oSat;
    logic                     oBusy;

    pi_loop_core #(
        .DATA_W(DATA_W), .GAIN_W(GAIN_W), .OUT_W(OUT_W),
        .INT_W(INT_W), .INT_LIMIT(INT_LIMIT), .SHIFT(SHIFT)
    ) dut (
        .iClk(iClk), .iRst(iRst),
        .iTarget_data(iTarget_data), .iCurrent_data(iCurrent_data),
        .iKp(iKp), .iKi(iKi), .iCal_en(iCal_en), .iClr_int(iClr_int),
        .oCal_data(oCal_data), .oCal_done(oCal_done), .oSat(oSat), .oBusy(oBusy)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        longint data;
        longint sat;
        longint acc;
    } exp_t;

    exp_t   sb_q[$];
    exp_t   mon_e;
    int     checks     = 0;
    int     failures   = 0;
    int     done_count = 0;
    longint m_int = 0;
    longint m_sat = 0;
    longint m_out = 0;

    task automatic check_val(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference model of one calculation; uses the gains currently driven on iKp/iKi
    task automatic model_push(input longint e, input bit clr_on);
        longint p, i, s;
        bit     hold;
        exp_t   x;
        hold = 1'b0;
`ifdef PI_ANTI_WINDUP_EN
        hold = (m_sat != 0) && ((e < 0) == (m_out < 0));
`endif
        if (clr_on) begin
            m_int = 0;
        end else if (!hold) begin
            m_int = m_int + e;
            if (m_int > INT_LIMIT)  m_int = INT_LIMIT;
            if (m_int < -INT_LIMIT) m_int = -INT_LIMIT;
        end
        p = longint'(iKp) * e;
        i = longint'(iKi) * m_int;
        s = (p >>> SHIFT) + (i >>> SHIFT);
        m_sat = 0;
        m_out = s;
        if (s > 2047)  begin m_out = 2047;  m_sat = 1; end
        if (s < -2048) begin m_out = -2048; m_sat = 1; end
        x.data = m_out;
        x.sat  = m_sat;
        x.acc  = m_int;
        sb_q.push_back(x);
    endtask

    always @(negedge iClk) begin
        if (!iRst && oCal_done) begin
            done_count++;
            if (sb_q.size() == 0) begin
                check_val("unexpected_done", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check_val("cal_data", longint'(oCal_data), mon_e.data);
                check_val("sat", longint'(oSat), mon_e.sat);
                check_val("int_acc", longint'(dut.int_acc_reg), mon_e.acc);
                $display("txn out=%0d sat=%0d int_acc=%0d", oCal_data, oSat, dut.int_acc_reg);
            end
        end
    end

    task automatic run_calc(input longint t, input longint c, input int k_p, input int k_i,
                            input bit clr_on, input string tag);
        int lat;
        @(negedge iClk);
        iTarget_data  = DATA_W'(t);
        iCurrent_data = DATA_W'(c);
        iKp           = GAIN_W'(k_p);
        iKi           = GAIN_W'(k_i);
        iClr_int      = clr_on;
        model_push(t - c, clr_on);
        iCal_en = 1'b1;
        @(posedge iClk); #1;
        iCal_en = 1'b0;
        check_val({tag, "_busy"}, longint'(oBusy), 1);
        lat = 0;
        while (!oCal_done && lat < 10) begin
            @(posedge iClk); #1;
            lat++;
        end
        check_val({tag, "_latency"}, lat, 4);
        @(posedge iClk); #1;
        check_val({tag, "_idle"}, longint'(oBusy), 0);
        iClr_int = 1'b0;
    endtask

    task automatic clear_int();
        @(negedge iClk);
        iClr_int = 1'b1;
        @(negedge iClk);
        iClr_int = 1'b0;
        m_int = 0;
    endtask

    initial begin
        int     snap;
        longint rt, rc;
        iRst = 1'b1; iCal_en = 1'b0; iClr_int = 1'b0;
        iTarget_data = '0; iCurrent_data = '0; iKp = '0; iKi = '0;
        repeat (3) @(posedge iClk);
        @(negedge iClk);
        iRst = 1'b0;
        check_val("rst_data", longint'(oCal_data), 0);
        check_val("rst_done", longint'(oCal_done), 0);
        check_val("rst_sat", longint'(oSat), 0);
        check_val("rst_busy", longint'(oBusy), 0);

        // Proportional path
        run_calc(100, 0, 256, 0, 1'b0, "p_pos");
        run_calc(0, 300, 256, 0, 1'b0, "p_neg");
        // Output saturation
        run_calc(100000, 0, 1023, 0, 1'b0, "sat_pos");
        run_calc(0, 100000, 1023, 0, 1'b0, "sat_neg");
        // Integrator accumulate and clear
        clear_int();
        for (int k = 0; k < 3; k++) run_calc(10, 0, 0, 256, 1'b0, "integ");
        run_calc(10, 0, 0, 256, 1'b1, "integ_clr");
        // Integrator clamp
        clear_int();
        for (int k = 0; k < 3; k++) run_calc(524287, 0, 0, 1, 1'b0, "clamp");
`ifdef PI_ANTI_WINDUP_EN
        check_val("clamp_final_acc", longint'(dut.int_acc_reg), 1048574);
`else
        check_val("clamp_final_acc", longint'(dut.int_acc_reg), 1048576);
`endif
        // Anti-windup behaviour
        clear_int();
        run_calc(100000, 0, 1023, 256, 1'b0, "aw1");
        run_calc(100000, 0, 1023, 256, 1'b0, "aw2");
`ifdef PI_ANTI_WINDUP_EN
        check_val("aw_acc", longint'(dut.int_acc_reg), 100000);
`else
        check_val("aw_acc", longint'(dut.int_acc_reg), 200000);
`endif
        // Random mixed patterns
        clear_int();
        for (int k = 0; k < 6; k++) begin
            rt = longint'($urandom_range(0, 1048575)) - 524288;
            rc = longint'($urandom_range(0, 1048575)) - 524288;
            run_calc(rt, rc, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'b0, "rand");
        end

        // iCal_en held high: exactly one calculation
        snap = done_count;
        @(negedge iClk);
        iTarget_data = 20'sd50; iCurrent_data = 20'sd0; iKp = 10'd256; iKi = 10'd0;
        model_push(50, 1'b0);
        iCal_en = 1'b1;
        repeat (20) @(negedge iClk);
        iCal_en = 1'b0;
        repeat (3) @(negedge iClk);
        check_val("hold_high_dones", done_count - snap, 1);

        // Second edge at E2 is dropped
        snap = done_count;
        @(negedge iClk);
        iTarget_data = -20'sd70; iCurrent_data = 20'sd0;
        model_push(-70, 1'b0);
        iCal_en = 1'b1;
        @(posedge iClk); #1 iCal_en = 1'b0;
        @(posedge iClk); #1 iCal_en = 1'b1;
        @(posedge iClk); #1 iCal_en = 1'b0;
        repeat (10) @(negedge iClk);
        check_val("second_edge_dones", done_count - snap, 1);

        // Reset at E2 aborts the calculation
        snap = done_count;
        @(negedge iClk);
        iTarget_data = 20'sd900; iCurrent_data = 20'sd0; iKi = 10'd5;
        iCal_en = 1'b1;
        @(posedge iClk); #1 iCal_en = 1'b0;
        @(posedge iClk); #1 iRst = 1'b1;
        @(posedge iClk); #1 iRst = 1'b0;
        m_int = 0; m_sat = 0; m_out = 0;
        check_val("abort_data", longint'(oCal_data), 0);
        check_val("abort_sat", longint'(oSat), 0);
        check_val("abort_busy", longint'(oBusy), 0);
        check_val("abort_acc", longint'(dut.int_acc_reg), 0);
        repeat (8) @(negedge iClk);
        check_val("abort_dones", done_count - snap, 0);

        // Fresh calculation after the abort
        run_calc(100, 0, 256, 0, 1'b0, "post_rst");
        repeat (2) @(negedge iClk);
        check_val("sb_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
